// File: rtl/am2958_bus_arbiter.sv
// am2958_bus_arbiter: round-robin owner selection for a shared tristate bus
// made of am2958 inverting driver banks. Drives the active-low g_ enables so
// that at most one bank is on. Every change of owner passes through one
// all-disabled turnaround cycle.
// Optional build macro AM2958_ARB_TENURE_EN: limits how long an owner may
// hold the bus while another requester is waiting (TENURE cycles).
module am2958_bus_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int TENURE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] g_,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic            turn
);

  // Parameter sanity, evaluated at elaboration only
  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("IDW must equal clog2(NREQ)");
  end
  if (TENURE < 1 || TENURE > 255) begin : g_bad_tenure
    $error("TENURE must be in 1..255");
  end

  // state is left as a plain named signal so checkers can probe it directly
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_nxt;
  logic [IDW-1:0]    sel;
  logic              found;
  logic [2*NREQ-1:0] req_rot2;
  logic [NREQ-1:0]   req_rot;
  logic [IDW:0]      sum;
  logic [NREQ-1:0]   g_nxt;
  logic [IDW-1:0]    gnt_nxt;
  logic              busy_nxt;
  logic              turn_nxt;
  logic              others;
  logic              forced;
  logic              release_bus;

  // Requests from anyone other than the current owner
  assign others = |(req & ~(NREQ'(1) << gnt_id));

`ifdef AM2958_ARB_TENURE_EN
  logic [7:0] ten_cnt;

  // Tenure counter: zero outside GRANT, counts GRANT cycles, saturates
  always_ff @(posedge clk) begin
    if (rst || state != GRANT) ten_cnt <= '0;
    else if (ten_cnt != 8'hff) ten_cnt <= ten_cnt + 8'd1;
  end

  assign forced = (state == GRANT) && others && (ten_cnt >= 8'(TENURE - 1));
`else
  assign forced = 1'b0;
`endif

  // Owner gives up the bus when it drops req, or is forced off by tenure
  assign release_bus = !req[gnt_id] || forced;

  // Rotate req so bit 0 is the ptr position, pick the first set bit,
  // then map the rotated index back to a requester number
  always_comb begin
    req_rot2 = {req, req} >> ptr;
    req_rot  = req_rot2[NREQ-1:0];
    found    = 1'b0;
    sel      = '0;
    sum      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW+1)'(i);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        sel   = sum[IDW-1:0];
      end
    end
  end

  // State and all outputs are registered; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      g_     <= '1;
      gnt_id <= '0;
      busy   <= 1'b0;
      turn   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      g_     <= g_nxt;
      gnt_id <= gnt_nxt;
      busy   <= busy_nxt;
      turn   <= turn_nxt;
    end
  end

  // Next-state: IDLE and TURN both arbitrate; GRANT waits for release
  always_comb begin
    state_nxt = state;
    case (state)
      GRANT:   if (release_bus) state_nxt = TURN;
      default: state_nxt = found ? GRANT : IDLE;
    endcase
  end

  // Next values of the registered outputs and the round-robin pointer
  always_comb begin
    g_nxt    = g_;
    gnt_nxt  = gnt_id;
    busy_nxt = busy;
    turn_nxt = 1'b0;
    ptr_nxt  = ptr;
    case (state)
      GRANT: begin
        if (release_bus) begin
          g_nxt    = '1;
          gnt_nxt  = '0;
          busy_nxt = 1'b0;
          turn_nxt = 1'b1;
          ptr_nxt  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
      default: begin
        if (found) begin
          g_nxt    = ~(NREQ'(1) << sel);
          gnt_nxt  = sel;
          busy_nxt = 1'b1;
        end else begin
          g_nxt    = '1;
          gnt_nxt  = '0;
          busy_nxt = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_am2958_bus_arbiter.sv
// Bench for am2958_bus_arbiter: directed scenarios plus random request
// traffic, every cycle compared against a behavioural model of the
// arbitration rules. Honours AM2958_ARB_TENURE_EN in the model as well.
module tb_am2958_bus_arbiter;

  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int TENURE = 4;
`ifdef AM2958_ARB_TENURE_EN
  localparam bit TEN_EN = 1'b1;
`else
  localparam bit TEN_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] g_;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            turn;

  am2958_bus_arbiter #(.NREQ(NREQ), .IDW(IDW), .TENURE(TENURE)) dut (
    .clk(clk), .rst(rst), .req(req),
    .g_(g_), .gnt_id(gnt_id), .busy(busy), .turn(turn)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // behavioural model: who owns the bus, was last cycle a handover,
  // where the round-robin search starts, how many cycles the owner has had
  bit m_busy;
  bit m_turn;
  int m_owner;
  int m_ptr;
  int m_held;

  function automatic bit bit_of(input logic [NREQ-1:0] q, input int idx);
    return ((int'(q) >> idx) & 1) == 1;
  endfunction

  task automatic model_step(input logic r, input logic [NREQ-1:0] q);
    bit wait_other;
    if (r) begin
      m_busy = 0; m_turn = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    end else if (m_busy) begin
      wait_other = 0;
      for (int k = 0; k < NREQ; k++)
        if (k != m_owner && bit_of(q, k)) wait_other = 1;
      if (!bit_of(q, m_owner) || (TEN_EN && wait_other && m_held + 1 >= TENURE)) begin
        m_busy = 0; m_turn = 1;
        m_ptr  = (m_owner + 1) % NREQ;
        m_owner = 0;
      end else begin
        m_held++;
      end
    end else begin
      m_turn = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!m_busy && bit_of(q, (m_ptr + k) % NREQ)) begin
          m_busy = 1; m_owner = (m_ptr + k) % NREQ; m_held = 0;
        end
      end
    end
  endtask

  // scoreboard of expected grant order, consumed when a new grant appears
  logic [IDW-1:0] exp_q[$];
  logic prev_busy = 1'b0;

  task automatic compare_all();
    logic [NREQ-1:0] exp_g;
    exp_g = m_busy ? ~(NREQ'(1) << m_owner) : '1;
    check("g_", g_, exp_g);
    check("gnt_id", gnt_id, m_busy ? m_owner : 0);
    check("busy", busy, m_busy);
    check("turn", turn, m_turn);
    check("one_low", ($countones(~g_) <= 1), 1);
    if (busy && !prev_busy && exp_q.size() > 0)
      check("order", gnt_id, exp_q.pop_front());
    prev_busy = busy;
  endtask

  // driver: present inputs away from the edge, advance model, check
  task automatic cycle(input logic r, input logic [NREQ-1:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    cycle(1'b1, NREQ'($urandom_range(0, 15)));
    cycle(1'b1, NREQ'($urandom_range(0, 15)));
  endtask

  initial begin
    logic [NREQ-1:0] q;
    @(negedge clk);

    // reset with random req
    do_reset();
    check("rst_g", g_, 4'b1111);

    // single request
    cycle(1'b0, 4'b0100);
    check("single_g", g_, 4'b1011);
    check("single_id", gnt_id, 2);
    cycle(1'b0, 4'b0100);
    cycle(1'b0, 4'b0000);
    check("single_turn", turn, 1);
    cycle(1'b0, 4'b0000);
    check("single_idle", {busy, turn}, 2'b00);

    // round-robin: all request, owner drops for one cycle after 2 cycles
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int c = 0; c < 24; c++) begin
      q = 4'b1111;
      if (m_busy && m_held >= 2) q[m_owner] = 1'b0;
      cycle(1'b0, q);
    end
    check("order_done", exp_q.size(), 0);
    exp_q.delete();

    // wrap: owner 3 releases while 0 waits, next grant goes to 0
    do_reset();
    cycle(1'b0, 4'b1000);
    check("wrap_own3", gnt_id, 3);
    cycle(1'b0, 4'b0001);
    cycle(1'b0, 4'b1001);
    check("wrap_to0", gnt_id, 0);
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b0000);

    // reset in the middle of a grant
    do_reset();
    cycle(1'b0, 4'b0010);
    cycle(1'b0, 4'b0010);
    cycle(1'b1, 4'b0010);
    check("midrst_g", g_, 4'b1111);
    cycle(1'b0, 4'b0010);
    check("midrst_id", gnt_id, 1);

    // tenure: two requesters, owner 0 never lets go
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      cycle(1'b0, 4'b0011);
      if (c == 4) check("ten_hold", g_, 4'b1110);
      if (c == 6) check("ten_g", g_, TEN_EN ? 4'b1101 : 4'b1110);
    end

    // random traffic: requests toggle occasionally, rare resets
    do_reset();
    q = '0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 4) == 0) q[b] = ~q[b];
      cycle($urandom_range(0, 99) == 0, q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/am2958_bus_arbiter.md
Name: am2958_bus_arbiter

Overview:
- Round-robin arbiter/sequencer for a shared tristate bus built from am2958 inverting drivers.
- Each requester owns one am2958 bank; the block drives the active-low g_ enables of those banks.
- Guarantees at most one enabled bank at any time.
- Inserts one all-disabled turnaround cycle between owners to prevent bus contention.

Parameters:
NREQ, 4, number of requesters / driver banks (2..16)
IDW, 2, width of gnt_id; must equal $clog2(NREQ)
TENURE, 8, max grant length in cycles (used only with AM2958_ARB_TENURE_EN; 1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active high
req  input  NREQ  bus request per requester; held high for as long as bus is wanted
g_  output  NREQ  active-low enables to am2958 banks; all-high or exactly one bit low
gnt_id  output  IDW  index of current owner; 0 when not busy
busy  output  1  high while some g_ bit is low
turn  output  1  high during the turnaround cycle

Behaviour:
- Reset (rst=1 at edge) values: g_ all 1, busy=0, gnt_id=0, turn=0, state=IDLE, rr pointer ptr=0. Reset also wins mid-grant: g_ goes all-high at that edge.
- All outputs are registered; no combinational path from req to g_.
- States: IDLE, GRANT, TURN.
- IDLE:
  - Arbitration: if any req bit is set, select the first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - At that edge: g_[sel]=0, gnt_id=sel, busy=1, state=GRANT.
  - Latency is one edge from sampled req to g_ low.
  - No request: remain in IDLE.
- GRANT:
  - Owner keeps the bus while req[owner]=1.
  - Other requests never preempt the owner, except under the optional feature.
  - On the edge sampling req[owner]=0: g_ all 1, busy=0, gnt_id=0, turn=1, ptr=(owner+1) mod NREQ, state=TURN.
- TURN:
  - Lasts exactly one cycle with all g_ high.
  - At the end of TURN, arbitration runs as in IDLE using the updated ptr.
  - Result: a waiting requester gets g_ low at the next edge, or the block goes to IDLE with turn=0.
- Back-to-back handover costs exactly one dead cycle.
- A previous owner re-raising req during TURN is lowest priority because ptr has already advanced.
- req pulses shorter than one cycle may be missed; requesters must hold req until granted.
- Single requester repeatedly cycling req: gets the bus again after each TURN.
- ptr wrap: owner NREQ-1 → ptr=0.

Optional Feature:
- Macro: AM2958_ARB_TENURE_EN.
- With the macro:
  - An 8-bit tenure counter clears on grant and increments each GRANT cycle.
  - When the counter reaches TENURE-1 and any other req bit is set, the owner is forcibly released at the next edge. The block enters TURN exactly as for a voluntary release, with ptr=owner+1.
  - With no competing request, the owner is not released.
- Without the macro: no counter, TENURE is ignored, and the owner holds the bus indefinitely.

Test Plan:
- Reset: assert rst for 2 cycles with random req → g_=1111, busy=0, gnt_id=0, turn=0.
- Single request: req=0100 from IDLE → after 1 edge g_=1011, gnt_id=2, busy=1. Drop req → g_=1111, turn=1 for one cycle, then IDLE.
- Contention/round-robin: req=1111 held, each owner dropping its req for 1 cycle after 2 cycles of tenure → grant order 0,1,2,3,0. Exactly one TURN cycle with g_=1111 between owners. Never two g_ bits low.
- Wrap: owner 3 releases while req=1001 → next grant goes to 0, not 3.
- Reset mid-grant: owner 1 active, rst=1 at one edge → g_=1111 at that edge. After rst drops with req=0010 → grant to 1 (ptr=0 scan).
- Tenure (macro defined, TENURE=4): req=0011, owner 0 holds req → forced release after 4 GRANT cycles, TURN, then g_=1101. Same stimulus without the macro → owner 0 keeps g_=1110 indefinitely.
